// File: rtl/dac_spi_tx.sv
// Serializer that sends the 16-bit DAC code as a 24-bit SPI frame (AD5662-class DAC).
// A frame starts on a code change or a start strobe. Updates made while a frame is in flight collapse into one follow-up frame.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | sync_n high, waiting for a code change, start or pending update
// S_SHIFT | sync_n low, 24 bits shifted out MSB first, 2*CLK_DIV clk per bit
// S_GAP   | sync_n high for SYNC_GAP*CLK_DIV clk before the next trigger
module dac_spi_tx #(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [7:0]  CTRL_BITS = 8'h00,
    parameter int unsigned SYNC_GAP  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data_in,
    input  logic        start,
    output logic        dac_sync_n,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        busy,
    output logic        done,
    output logic [15:0] sent_data
);

    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_CYC  = SYNC_GAP * CLK_DIV;
    localparam int unsigned GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          half_q, half_d;
    logic [4:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [22:0]   shreg_q, shreg_d;
    logic [15:0]   code_q, code_d;
    logic [15:0]   sent_q, sent_d;
    logic          pending_q, pending_d;
    logic          sync_n_q, sync_n_d;
    logic          sclk_q, sclk_d;
    logic          din_q, din_d;
    logic          done_q, done_d;
    logic          trigger;

    assign trigger = start || pending_q || (data_in != sent_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            half_q    <= 1'b0;
            bit_q     <= '0;
            gap_q     <= '0;
            shreg_q   <= '0;
            code_q    <= '0;
            sent_q    <= '0;
            pending_q <= 1'b0;
            sync_n_q  <= 1'b1;
            sclk_q    <= 1'b1;
            din_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            shreg_q   <= shreg_d;
            code_q    <= code_d;
            sent_q    <= sent_d;
            pending_q <= pending_d;
            sync_n_q  <= sync_n_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        half_d    = half_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        shreg_d   = shreg_q;
        code_d    = code_q;
        sent_d    = sent_q;
        pending_d = pending_q;
        sync_n_d  = sync_n_q;
        sclk_d    = sclk_q;
        din_d     = din_q;
        done_d    = 1'b0;

        // The frame in flight uses its latched copy. A new code or a start only leaves a pending flag.
        if (state_q != S_IDLE && (start || data_in != code_q))
            pending_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d   = S_SHIFT;
                    code_d    = data_in;
                    shreg_d   = {CTRL_BITS[6:0], data_in};
                    din_d     = CTRL_BITS[7];
                    sync_n_d  = 1'b0;
                    sclk_d    = 1'b1;
                    bit_d     = 5'd23;
                    half_d    = 1'b0;
                    div_d     = DIV_LOAD;
                    pending_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DW'(1);
                end else begin
                    div_d = DIV_LOAD;
                    if (!half_q) begin
                        half_d = 1'b1;
                        sclk_d = 1'b0;
                    end else if (bit_q == 5'd0) begin
                        state_d  = S_GAP;
                        sync_n_d = 1'b1;
                        sclk_d   = 1'b1;
                        din_d    = 1'b0;
                        sent_d   = code_q;
                        done_d   = 1'b1;
                        gap_d    = GAP_LOAD;
                    end else begin
                        half_d  = 1'b0;
                        sclk_d  = 1'b1;
                        bit_d   = bit_q - 5'd1;
                        din_d   = shreg_q[22];
                        shreg_d = {shreg_q[21:0], 1'b0};
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0)
                    state_d = S_IDLE;
                else
                    gap_d = gap_q - GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dac_sync_n = sync_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign done       = done_q;
    assign sent_data  = sent_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx. A line monitor decodes frames from the serial pins.
// Frames are checked against the codes the bench applied, with the latest update winning.
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] data0, data1;
    logic        start0, start1;
    logic        sync_n0, sclk0, din0, busy0, done0;
    logic        sync_n1, sclk1, din1, busy1, done1;
    logic [15:0] sent0, sent1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dac_spi_tx u_dut0 (
        .clk(clk), .reset_n(reset_n), .data_in(data0), .start(start0),
        .dac_sync_n(sync_n0), .dac_sclk(sclk0), .dac_din(din0),
        .busy(busy0), .done(done0), .sent_data(sent0)
    );

    dac_spi_tx #(.CLK_DIV(1), .CTRL_BITS(8'h30), .SYNC_GAP(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .data_in(data1), .start(start1),
        .dac_sync_n(sync_n1), .dac_sclk(sclk1), .dac_din(din1),
        .busy(busy1), .done(done1), .sent_data(sent1)
    );

    // Line monitor: each completed frame records its bits, its low time, the gap before it,
    // the first sclk fall offset, the sclk period and whether done was high when sync rose.
    logic        snc[2], sck[2], dn[2], dne[2];
    logic        psync[2], psck[2];
    logic [23:0] sh[2];
    int          lowc[2], highc[2], nb[2], ff[2], per[2], gaprec[2];
    logic [23:0] frm[2][64];
    int          flen[2][64], fgap[2][64], fff[2][64], fper[2][64], fnb[2][64];
    logic        fdone[2][64];
    int          nfr[2] = '{0, 0};
    int          ndone[2] = '{0, 0};

    assign snc[0] = sync_n0; assign sck[0] = sclk0; assign dn[0] = din0; assign dne[0] = done0;
    assign snc[1] = sync_n1; assign sck[1] = sclk1; assign dn[1] = din1; assign dne[1] = done1;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                psync[i] = 1'b1; psck[i] = 1'b1;
                lowc[i] = 0; highc[i] = 0; nb[i] = 0; ff[i] = -1; per[i] = -1; sh[i] = '0;
            end else begin
                if (dne[i]) ndone[i]++;
                if (snc[i] == 1'b0) begin
                    if (psync[i]) begin
                        gaprec[i] = highc[i]; lowc[i] = 0; nb[i] = 0; ff[i] = -1; per[i] = -1;
                    end
                    if (psck[i] && !sck[i]) begin
                        if (nb[i] == 0) ff[i] = lowc[i];
                        if (nb[i] == 1) per[i] = lowc[i] - ff[i];
                        sh[i] = {sh[i][22:0], dn[i]};
                        nb[i]++;
                    end
                    lowc[i]++;
                end else begin
                    if (!psync[i] && nfr[i] < 64) begin
                        frm[i][nfr[i]] = sh[i];   flen[i][nfr[i]] = lowc[i];
                        fgap[i][nfr[i]] = gaprec[i]; fff[i][nfr[i]] = ff[i];
                        fper[i][nfr[i]] = per[i];  fnb[i][nfr[i]] = nb[i];
                        fdone[i][nfr[i]] = dne[i];
                        nfr[i]++;
                        highc[i] = 0;
                    end
                    highc[i]++;
                end
                psync[i] = snc[i]; psck[i] = sck[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_nfr(input int i, input int n, input string tag);
        int c = 0;
        while (nfr[i] < n && c < 3000) begin @(posedge clk); c++; end
        check(tag, 32'(nfr[i] >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy0 !== 1'b0 && c < 1000) begin @(negedge clk); c++; end
        check(tag, {31'd0, busy0}, 32'd0);
    endtask

    task automatic wait_sync_low(input string tag);
        int c = 0;
        while (sync_n0 !== 1'b0 && c < 20) begin @(negedge clk); c++; end
        check(tag, {31'd0, sync_n0}, 32'd0);
    endtask

    task automatic check_frame(input int i, input int k, input logic [23:0] exp_frame, input string tag);
        check({tag, "_bits"}, {8'd0, frm[i][k]}, {8'd0, exp_frame});
        check({tag, "_nbits"}, 32'(fnb[i][k]), 32'd24);
        check({tag, "_done"}, {31'd0, fdone[i][k]}, 32'd1);
    endtask

    logic [15:0] model_sent;
    int          base, done_base;

    initial begin
        reset_n = 1'b0; data0 = '0; data1 = '0; start0 = 1'b0; start1 = 1'b0;
        model_sent = '0;
        cyc(3);
        check("rst_sync", {31'd0, sync_n0}, 32'd1);
        check("rst_sclk", {31'd0, sclk0}, 32'd1);
        check("rst_din",  {31'd0, din0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_sent", {16'd0, sent0}, 32'd0);
        reset_n = 1'b1;
        cyc(50);
        check("idle_nofr", 32'(nfr[0]), 32'd0);
        check("idle_sync", {31'd0, sync_n0}, 32'd1);
        check("idle_busy", {31'd0, busy0}, 32'd0);

        // A single code change
        data0 = 16'hA5C3;
        wait_nfr(0, 1, "f1_wait");
        check_frame(0, 0, 24'h00A5C3, "f1");
        check("f1_len", 32'(flen[0][0]), 32'd192);
        check("f1_first_fall", 32'(fff[0][0]), 32'd4);
        check("f1_period", 32'(fper[0][0]), 32'd8);
        wait_idle("f1_idle");
        check("f1_sent", {16'd0, sent0}, 32'h0000A5C3);
        check("f1_ndone", 32'(ndone[0]), 32'd1);

        // Two updates while a frame is in flight collapse into one follow-up frame
        base = nfr[0];
        data0 = 16'h1234;
        wait_sync_low("co_start");
        cyc(20);
        data0 = 16'h5678;
        wait_nfr(0, base + 1, "co_wait1");
        cyc(2);
        data0 = 16'h9ABC;
        wait_nfr(0, base + 2, "co_wait2");
        check_frame(0, base, 24'h001234, "co_a");
        check_frame(0, base + 1, 24'h009ABC, "co_b");
        check("co_gap", 32'(fgap[0][base + 1]), 32'd9);
        wait_idle("co_idle");
        cyc(300);
        check("co_count", 32'(nfr[0]), 32'(base + 2));

        // start with an unchanged code, then start and a change in the same cycle
        data0 = 16'h00FF;
        wait_nfr(0, nfr[0] + 1, "st_prep");
        wait_idle("st_prep_idle");
        cyc(5);
        base = nfr[0];
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        wait_nfr(0, base + 1, "st_wait");
        check_frame(0, base, 24'h0000FF, "st");
        wait_idle("st_idle");
        cyc(300);
        check("st_count", 32'(nfr[0]), 32'(base + 1));
        base = nfr[0];
        data0 = 16'h0F0F; start0 = 1'b1; cyc(1); start0 = 1'b0;
        wait_nfr(0, base + 1, "sd_wait");
        check_frame(0, base, 24'h000F0F, "sd");
        wait_idle("sd_idle");
        cyc(300);
        check("sd_count", 32'(nfr[0]), 32'(base + 1));

        // Reset during bit 10 of a frame
        base = nfr[0];
        done_base = ndone[0];
        data0 = 16'h0BAD;
        wait_sync_low("rm_start");
        cyc(13 * 8 + 2);
        reset_n = 1'b0;
        #1;
        check("rm_sync", {31'd0, sync_n0}, 32'd1);
        check("rm_sclk", {31'd0, sclk0}, 32'd1);
        check("rm_busy", {31'd0, busy0}, 32'd0);
        check("rm_sent", {16'd0, sent0}, 32'd0);
        cyc(3);
        check("rm_nodone", 32'(ndone[0]), 32'(done_base));
        check("rm_nofr", 32'(nfr[0]), 32'(base));
        data0 = 16'h0001;
        reset_n = 1'b1;
        wait_nfr(0, base + 1, "rm_wait");
        check_frame(0, base, 24'h000001, "rm");
        check("rm_len", 32'(flen[0][base]), 32'd192);
        wait_idle("rm_idle");
        cyc(300);
        check("rm_count", 32'(nfr[0]), 32'(base + 1));
        model_sent = 16'h0001;

        // Random codes with random mid-frame updates. The latest applied code is always the one sent next.
        for (int it = 0; it < 6; it++) begin
            logic [15:0] v, x;
            logic [15:0] expq[$];
            int nx;
            expq = {};
            base = nfr[0];
            v = 16'($urandom);
            if (v == model_sent) v = ~v;
            data0 = v;
            expq.push_back(v);
            wait_sync_low("rnd_start");
            nx = $urandom_range(0, 3);
            x = v;
            for (int k = 0; k < nx; k++) begin
                cyc($urandom_range(5, 40));
                x = 16'($urandom);
                if (x == v) x = ~x;
                data0 = x;
            end
            if (nx > 0) expq.push_back(x);
            wait_nfr(0, base + expq.size(), "rnd_wait");
            wait_idle("rnd_idle");
            cyc(300);
            check("rnd_count", 32'(nfr[0]), 32'(base + expq.size()));
            for (int k = 0; k < expq.size(); k++)
                check("rnd_frame", {8'd0, frm[0][base + k]}, {16'd0, expq[k]});
            model_sent = expq[expq.size() - 1];
            check("rnd_sent", {16'd0, sent0}, {16'd0, model_sent});
        end

        // Fastest divider with a nonzero control field
        check("d1_nofr", 32'(nfr[1]), 32'd0);
        data1 = 16'hFFFF;
        wait_nfr(1, 1, "d1_wait");
        check_frame(1, 0, 24'h30FFFF, "d1");
        check("d1_len", 32'(flen[1][0]), 32'd48);
        check("d1_first_fall", 32'(fff[1][0]), 32'd1);
        check("d1_period", 32'(fper[1][0]), 32'd2);
        cyc(5);
        check("d1_sent", {16'd0, sent1}, 32'h0000FFFF);
        check("d1_busy", {31'd0, busy1}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
